// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int CSUM_W = BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } state_t;

    // States in which a load is in progress and bytes are accepted.
    function automatic logic is_active(input state_t s);
        return s inside {ST_COUNT, ST_HI, ST_LO, ST_CHECK};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
interface prog_loader_if #(
    parameter int ADDR_W = 6
);
    import prog_loader_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    // Environment side: produces bytes, observes memory writes.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side: consumes bytes, drives memory writes.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/prog_loader_timeout.sv
// Idle-cycle counter: cleared on activity, counts while enabled, flags expiry.
module prog_loader_timeout #(
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    // Next count: clear has priority, otherwise advance while enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + TO_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry fires on the edge that would make the idle count reach TIMEOUT.
    always_comb begin
        expire = en && !clr && (count_q == TO_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: count byte, big-endian 16-bit words, XOR checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    prog_loader_if.slave    bus,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic            cpu_rst_n,
    output logic [ADDR_W:0] words_loaded
);

    state_t state_q;
    state_t state_d;

    logic active;
    logic hs;
    logic start_acc;
    logic count_ok;
    logic last_word;
    logic csum_ok;
    logic expire;
    logic timer_clr;

    logic [ADDR_W:0]       n_q,         n_d;
    logic [BYTE_W-1:0]     hi_q,        hi_d;
    logic [CSUM_W-1:0]     csum_q,      csum_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]       words_q,     words_d;

    // Handshake and decision terms shared by the FSM and datapath.
    always_comb begin
        active    = is_active(state_q);
        hs        = active && bus.in_valid;
        start_acc = start && !active;
        timer_clr = hs || start_acc;
        count_ok  = (bus.in_data != '0) && ({1'b0, bus.in_data} <= 9'(DEPTH));
        last_word = (words_q == (n_q - (ADDR_W + 1)'(1)));
        csum_ok   = (bus.in_data == csum_q);
    end

    prog_loader_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .en     (active),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (hs)          state_d = count_ok ? ST_HI : ST_ERR;
                else if (expire) state_d = ST_ERR;
            end
            ST_HI: begin
                if (hs)          state_d = ST_LO;
                else if (expire) state_d = ST_ERR;
            end
            ST_LO: begin
                if (hs)          state_d = last_word ? ST_CHECK : ST_HI;
                else if (expire) state_d = ST_ERR;
            end
            ST_CHECK: begin
                if (hs)          state_d = csum_ok ? ST_DONE : ST_ERR;
                else if (expire) state_d = ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: status decoded from state, memory port straight from flops.
    always_comb begin
        bus.in_ready  = active;
        busy          = active;
        done          = (state_q == ST_DONE);
        err           = (state_q == ST_ERR);
        cpu_rst_n     = (state_q == ST_DONE);
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        words_loaded  = words_q;
    end

    // Datapath next values: count, high byte, checksum and write port.
    always_comb begin
        n_d         = n_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
        if (start_acc) begin
            words_d    = '0;
            csum_d     = '0;
            mem_addr_d = '0;
        end else if (hs) begin
            case (state_q)
                ST_COUNT: begin
                    if (count_ok) n_d = (ADDR_W + 1)'(bus.in_data);
                    csum_d = csum_q ^ bus.in_data;
                end
                ST_HI: begin
                    hi_d   = bus.in_data;
                    csum_d = csum_q ^ bus.in_data;
                end
                ST_LO: begin
                    // Word index equals words written so far; N <= DEPTH keeps it in range.
                    mem_wdata_d = {hi_q, bus.in_data};
                    mem_addr_d  = words_q[ADDR_W-1:0];
                    mem_we_d    = 1'b1;
                    words_d     = words_q + (ADDR_W + 1)'(1);
                    csum_d      = csum_q ^ bus.in_data;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q         <= '0;
            hi_q        <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            words_q     <= '0;
        end else begin
            n_q         <= n_d;
            hi_q        <= hi_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a byte-index reference model.
module tb_prog_loader;

    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, err, cpu_rst_n;
    logic [ADDR_W:0] words_loaded;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

    prog_loader #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus_if),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cpu_rst_n    (cpu_rst_n),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position of each accepted byte within the load decides its role.
    bit          m_active = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    bit          m_we = 0;
    int          m_addr = 0;
    int          m_wdata = 0;
    int          m_words = 0;
    int          m_idle = 0;
    int          m_k = 0;
    int          m_n = 0;
    logic [7:0]  m_x = 0;
    logic [7:0]  m_hi = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0; m_done = 0; m_err = 0; m_we = 0;
                m_addr = 0; m_wdata = 0; m_words = 0; m_idle = 0;
            end else begin
                m_we = 0;
                if (!m_active) begin
                    if (start) begin
                        m_active = 1; m_k = 0; m_x = 0; m_words = 0; m_addr = 0;
                        m_done = 0; m_err = 0; m_idle = 0;
                    end
                end else if (bus_if.in_valid) begin
                    m_idle = 0;
                    if (m_k == 0) begin
                        if (bus_if.in_data == 0 || int'(bus_if.in_data) > DEPTH) begin
                            m_active = 0; m_err = 1;
                        end else begin
                            m_n = int'(bus_if.in_data);
                            m_x ^= bus_if.in_data;
                            m_k = 1;
                        end
                    end else if (m_k <= 2 * m_n) begin
                        m_x ^= bus_if.in_data;
                        if (m_k % 2 == 1) begin
                            m_hi = bus_if.in_data;
                        end else begin
                            m_wdata = int'({m_hi, bus_if.in_data});
                            m_addr  = m_k / 2 - 1;
                            m_we    = 1;
                            m_words++;
                        end
                        m_k++;
                    end else begin
                        m_active = 0;
                        if (bus_if.in_data == m_x) m_done = 1;
                        else                       m_err  = 1;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_active = 0; m_err = 1;
                    end
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy",         busy,                m_active);
            chk("in_ready",     bus_if.in_ready,     m_active);
            chk("done",         done,                m_done);
            chk("err",          err,                 m_err);
            chk("cpu_rst_n",    cpu_rst_n,           m_done);
            chk("mem_we",       bus_if.mem_we,       m_we);
            chk("mem_addr",     bus_if.mem_addr,     m_addr);
            chk("mem_wdata",    bus_if.mem_wdata,    m_wdata);
            chk("words_loaded", words_loaded,        m_words);
        end
    end

    // Log of observed memory writes, used by the literal checks.
    int log_n = 0;
    int log_addr [0:255];
    int log_data [0:255];

    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.mem_we && log_n < 256) begin
                log_addr[log_n] = int'(bus_if.mem_addr);
                log_data[log_n] = int'(bus_if.mem_wdata);
                log_n++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit acc;
        acc = 0;
        bus_if.in_data  = b;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.in_ready) begin
                acc = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        if (!acc) chk("send_accept", acc, 1);
    endtask

    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},      busy,             0);
        chk({tag, "_in_ready"},  bus_if.in_ready,  0);
        chk({tag, "_done"},      done,             0);
        chk({tag, "_err"},       err,              0);
        chk({tag, "_cpu_rst_n"}, cpu_rst_n,        0);
        chk({tag, "_mem_we"},    bus_if.mem_we,    0);
        chk({tag, "_mem_addr"},  bus_if.mem_addr,  0);
        chk({tag, "_mem_wdata"}, bus_if.mem_wdata, 0);
        chk({tag, "_words"},     words_loaded,     0);
    endtask

    initial begin
        int base;
        int cyc;
        logic [7:0] data [0:127];
        logic [7:0] x;
        logic [7:0] q[$];

        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal two-word load, back-to-back bytes.
        base = log_n;
        pulse_start();
        q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_list(q);
        @(negedge clk);
        chk("nom_done",   done,         1);
        chk("nom_err",    err,          0);
        chk("nom_cpu",    cpu_rst_n,    1);
        chk("nom_words",  words_loaded, 2);
        chk("nom_nwr",    log_n - base, 2);
        chk("nom_addr0",  log_addr[base],     0);
        chk("nom_data0",  log_data[base],     16'h1234);
        chk("nom_addr1",  log_addr[base + 1], 1);
        chk("nom_data1",  log_data[base + 1], 16'hABCD);

        // Same stream with a wrong checksum.
        base = log_n;
        pulse_start();
        q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_list(q);
        @(negedge clk);
        chk("bad_done",  done,         0);
        chk("bad_err",   err,          1);
        chk("bad_cpu",   cpu_rst_n,    0);
        chk("bad_nwr",   log_n - base, 2);

        // Illegal counts 0 and DEPTH+1.
        base = log_n;
        pulse_start();
        send(8'h00);
        chk("cnt0_err",  err, 1);
        chk("cnt0_busy", busy, 0);
        pulse_start();
        send(8'h41);
        @(negedge clk);
        chk("cnt65_err", err, 1);
        chk("cnt_nwr",   log_n - base, 0);

        // Full depth with random data and random gaps.
        base = log_n;
        x = 8'h40;
        for (int i = 0; i < 128; i++) begin
            data[i] = 8'($urandom);
            x ^= data[i];
        end
        pulse_start();
        send(8'h40);
        for (int i = 0; i < 128; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bus_if.in_data = 8'($urandom);
                @(negedge clk);
            end
            send(data[i]);
        end
        send(x);
        @(negedge clk);
        chk("full_done",  done,         1);
        chk("full_words", words_loaded, 64);
        chk("full_nwr",   log_n - base, 64);
        for (int i = 0; i < 64; i++) begin
            chk("full_addr", log_addr[base + i], i);
            chk("full_data", log_data[base + i], int'({data[2 * i], data[2 * i + 1]}));
        end

        // Timeout: count 1, one high byte, then silence.
        pulse_start();
        send(8'h01);
        send(8'h55);
        cyc = 0;
        while (!err && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_cycles",   cyc,             TIMEOUT);
        chk("to_err",      err,             1);
        chk("to_in_ready", bus_if.in_ready, 0);
        chk("to_words",    words_loaded,    0);

        // Asynchronous reset while waiting for a low byte.
        pulse_start();
        q = '{8'h03, 8'h9A, 8'hBC, 8'h77};
        send_list(q);
        chk("pre_rst_words", words_loaded, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reload, with a start pulse while busy that must be ignored.
        base = log_n;
        pulse_start();
        send(8'h02);
        pulse_start();
        q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_list(q);
        @(negedge clk);
        chk("reload_done",  done,         1);
        chk("reload_words", words_loaded, 2);
        chk("reload_nwr",   log_n - base, 2);
        chk("reload_data1", log_data[base + 1], 16'hABCD);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Serial program loader that fills the 64 x 16-bit instruction memory at run time, replacing build-time file preload. It accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake and assembles big-endian 16-bit words. It writes them through the memory write port, checks a trailing XOR checksum, and holds the CPU in reset until a load completes successfully.

Parameters:
ADDR_W, 6, instruction memory address width
DEPTH, 64, instruction memory words; must equal 2**ADDR_W
TIMEOUT, 1000000, max idle clk cycles between bytes once a load has started
TO_W, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a new load; ignored while busy
in_data  in  8  incoming byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte; transfer when in_valid && in_ready
mem_we  out  1  instruction memory write enable, one-cycle pulse
mem_addr  out  ADDR_W  write address
mem_wdata  out  16  write data, {hi_byte, lo_byte}
busy  out  1  load in progress
done  out  1  last load succeeded; sticky until next start
err  out  1  last load failed; sticky until next start
cpu_rst_n  out  1  CPU reset, active-low; released only in DONE
words_loaded  out  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_rst_n=0, words_loaded=0, checksum=0, timer=0. Reset mid-load aborts silently. Partially written memory is not cleared.
- States: IDLE, COUNT, HI, LO, CHECK, DONE, ERR.
- IDLE/DONE/ERR: on start go to COUNT. Clear done, err, words_loaded, checksum and timer. Set mem_addr=0 and cpu_rst_n=0.
- in_ready=1 exactly in COUNT, HI, LO and CHECK. busy=1 in the same states.
- COUNT: byte N = word count. Valid range 1..DEPTH; 0 or >DEPTH -> ERR. Otherwise store N, checksum ^= byte, go to HI.
- HI: latch high byte, checksum ^= byte, go to LO.
- LO: on accept, register mem_wdata={hi,byte} and mem_addr=word index, checksum ^= byte.
  - mem_we=1 in the following cycle only, so write latency is 1 cycle after the LO handshake.
  - words_loaded increments with mem_we.
  - If the word index was N-1 go to CHECK, else HI.
- CHECK: accepted byte compared with checksum (XOR of count byte and all data bytes). Equal -> DONE, else ERR.
- DONE: done=1, cpu_rst_n=1 (registered, one cycle after CHECK accept).
- ERR: err=1, cpu_rst_n stays 0.
- Timeout: in COUNT/HI/LO/CHECK the timer counts cycles without a handshake and resets to 0 on every handshake. Reaching TIMEOUT -> ERR.
- start while busy: ignored. start and a byte in the same cycle in IDLE: the byte is not accepted, because in_ready is 0 in IDLE.
- mem_addr wrap: cannot occur; N<=DEPTH, so the index never exceeds DEPTH-1.
- A back-to-back byte every cycle is sustained; the write pulse overlaps the next HI accept.

Decomposition:
- Shared package: state enum, BYTE_W=8, WORD_W=16, checksum width constant.
- Sub-module: loader_timeout (counter with clear, enable and expire) is natural. Everything else stays in one FSM module.

Test Plan:
- Nominal load: start; bytes 02,12,34,AB,CD,42 back-to-back -> mem_we at addr0=0x1234 and addr1=0xABCD, each one cycle after LO; done=1, cpu_rst_n=1, words_loaded=2, err=0.
- Bad checksum: same stream with final byte 43 -> both writes occur, err=1, done=0, cpu_rst_n=0.
- Illegal count: start; byte 00 -> ERR immediately, no mem_we. Repeat with 41 (65) -> ERR.
- Full depth: count 40 (64), 128 data bytes with in_valid toggling randomly, correct checksum -> 64 writes at addr 0..63, done=1, words_loaded=64.
- Timeout with TIMEOUT=16: start; bytes 01,55 then silence -> err=1 exactly 16 cycles after the last handshake, in_ready=0.
- Reset mid-load, then a start pulse issued while busy: assert rst_n=0 during LO -> all outputs return to reset values asynchronously. Reload then succeeds; a start pulse issued while busy is ignored.
